// File: rtl/network_interface_if.sv
`default_nettype none
// ============================================================================
//  Module      : pa_noc (package) / network_interface_if (interface)
//  Description : NoC-wide packet width and the grouped core/router signal
//                bundle for the network interface.
//                Port summary (through the modports):
//                  core TX : i_txData, i_txDestRow, i_txDestCol, i_txValid,
//                            o_txReady
//                  router  : o_routerPacket, o_routerValid, i_routerReady,
//                            i_routerPacket, i_routerValid, o_routerReady
//                  core RX : o_rxData, o_rxValid, i_rxReady
//                  status  : o_rxOverflow, o_txCount, o_rxCount,
//                            o_rxMisroute (only with NI_DEST_CHECK_EN)
//                Modport "slave" is the NI side; "master" is the
//                core/router environment side.
//  Revision    : 1.0 - initial release
// ============================================================================

package pa_noc;
  localparam int PACKET_WIDTH = 12;
endpackage

interface network_interface_if #(
  parameter int GRID_WIDTH = 4,
  parameter int CNT_W      = 16
);
  localparam int COORD_WIDTH = $clog2(GRID_WIDTH);
  localparam int PAYLOAD_W   = pa_noc::PACKET_WIDTH - 2 * COORD_WIDTH;

  logic [PAYLOAD_W-1:0]           i_txData;
  logic [COORD_WIDTH-1:0]         i_txDestRow;
  logic [COORD_WIDTH-1:0]         i_txDestCol;
  logic                           i_txValid;
  logic                           o_txReady;
  logic [pa_noc::PACKET_WIDTH-1:0] o_routerPacket;
  logic                           o_routerValid;
  logic                           i_routerReady;
  logic [pa_noc::PACKET_WIDTH-1:0] i_routerPacket;
  logic                           i_routerValid;
  logic                           o_routerReady;
  logic [PAYLOAD_W-1:0]           o_rxData;
  logic                           o_rxValid;
  logic                           i_rxReady;
  logic                           o_rxOverflow;
  logic [CNT_W-1:0]               o_txCount;
  logic [CNT_W-1:0]               o_rxCount;
`ifdef NI_DEST_CHECK_EN
  logic                           o_rxMisroute;
`endif

  modport slave (
    input  i_txData, i_txDestRow, i_txDestCol, i_txValid,
    output o_txReady,
    output o_routerPacket, o_routerValid,
    input  i_routerReady, i_routerPacket, i_routerValid,
    output o_routerReady,
    output o_rxData, o_rxValid,
    input  i_rxReady,
`ifdef NI_DEST_CHECK_EN
    output o_rxMisroute,
`endif
    output o_rxOverflow, o_txCount, o_rxCount
  );

  modport master (
    output i_txData, i_txDestRow, i_txDestCol, i_txValid,
    input  o_txReady,
    input  o_routerPacket, o_routerValid,
    output i_routerReady, i_routerPacket, i_routerValid,
    input  o_routerReady,
    input  o_rxData, o_rxValid,
    output i_rxReady,
`ifdef NI_DEST_CHECK_EN
    input  o_rxMisroute,
`endif
    input  o_rxOverflow, o_txCount, o_rxCount
  );
endinterface

`default_nettype wire

// File: rtl/network_interface.sv
`default_nettype none
// ============================================================================
//  Module      : network_interface
//  Description : Local NI between a core and its mesh router NI port.
//                TX: assembles {payload, dest row, dest col} into a 2-entry
//                FIFO and injects into the router. RX: buffers router
//                packets in a 2**RX_ADDR_W FIFO and hands payloads to the
//                core over valid/ready.
//                Ports: i_clk, i_srst (sync, active-high) and the
//                network_interface_if.slave bundle (see interface file).
//                Optional macro NI_DEST_CHECK_EN: drop incoming packets not
//                addressed to (NI_ROW, NI_COL) and flag o_rxMisroute.
//  Revision    : 1.0 - initial release
// ============================================================================

module network_interface #(
  parameter int GRID_WIDTH = 4,
  parameter int NI_ROW     = 0,
  parameter int NI_COL     = 0,
  parameter int RX_ADDR_W  = 2,
  parameter int CNT_W      = 16
) (
  input  wire logic           i_clk,
  input  wire logic           i_srst,
  network_interface_if.slave  bus
);

  localparam int COORD_WIDTH = $clog2(GRID_WIDTH);
  localparam int PKT_W       = pa_noc::PACKET_WIDTH;
  localparam int PAYLOAD_W   = PKT_W - 2 * COORD_WIDTH;
  localparam int RX_DEPTH    = 1 << RX_ADDR_W;
  localparam logic [RX_ADDR_W:0] RX_FULL_CNT   = (RX_ADDR_W + 1)'(RX_DEPTH);
  localparam logic [RX_ADDR_W:0] RX_ALMOST_CNT = (RX_ADDR_W + 1)'(RX_DEPTH - 1);

  // --------------------------------------------------------------------------
  // TX path: 2-entry packet FIFO
  // --------------------------------------------------------------------------
  logic [PKT_W-1:0] tx_mem [2];
  logic             tx_wr_ptr;
  logic             tx_rd_ptr;
  logic [1:0]       tx_count;
  logic             tx_push;
  logic             tx_pop;
  logic [CNT_W-1:0] tx_pkt_cnt;

  assign bus.o_txReady = (tx_count != 2'd2);
  assign tx_push       = bus.i_txValid && (tx_count != 2'd2);
  // Router FIFO captures on valid alone, so valid already implies acceptance.
  assign tx_pop        = (tx_count != 2'd0) && bus.i_routerReady;

  assign bus.o_routerValid  = tx_pop;
  assign bus.o_routerPacket = tx_pop ? tx_mem[tx_rd_ptr] : '0;
  assign bus.o_txCount      = tx_pkt_cnt;

  always_ff @(posedge i_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= {bus.i_txData, bus.i_txDestRow, bus.i_txDestCol};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      tx_wr_ptr  <= 1'b0;
      tx_rd_ptr  <= 1'b0;
      tx_count   <= 2'd0;
      tx_pkt_cnt <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= ~tx_wr_ptr;
      if (tx_pop) begin
        tx_rd_ptr  <= ~tx_rd_ptr;
        tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
      end
      tx_count <= tx_count + {1'b0, tx_push} - {1'b0, tx_pop};
    end
  end

  // --------------------------------------------------------------------------
  // RX path: payload FIFO
  // --------------------------------------------------------------------------
  logic [PAYLOAD_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_ADDR_W-1:0] rx_wr_ptr;
  logic [RX_ADDR_W-1:0] rx_rd_ptr;
  logic [RX_ADDR_W:0]   rx_count;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 dest_ok;
  logic                 rx_overflow;
  logic [CNT_W-1:0]     rx_pkt_cnt;

`ifdef NI_DEST_CHECK_EN
  logic rx_misroute;
  assign dest_ok = (bus.i_routerPacket[2*COORD_WIDTH-1:COORD_WIDTH] == COORD_WIDTH'(NI_ROW))
                && (bus.i_routerPacket[COORD_WIDTH-1:0] == COORD_WIDTH'(NI_COL));
  assign bus.o_rxMisroute = rx_misroute;
`else
  // Destination fields are deliberately ignored in this build.
  logic unused_dest_bits;
  assign unused_dest_bits = ^bus.i_routerPacket[2*COORD_WIDTH-1:0];
  assign dest_ok = 1'b1;
`endif

  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = !rx_empty && bus.i_rxReady;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign rx_push  = bus.i_routerValid && dest_ok && (!rx_full || rx_pop);

  // Deassert one early: the router may already have a packet in flight.
  assign bus.o_routerReady = (rx_count < RX_ALMOST_CNT);
  assign bus.o_rxValid     = !rx_empty;
  assign bus.o_rxData      = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign bus.o_rxOverflow  = rx_overflow;
  assign bus.o_rxCount     = rx_pkt_cnt;

  always_ff @(posedge i_clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= bus.i_routerPacket[PKT_W-1:2*COORD_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
      rx_pkt_cnt  <= '0;
`ifdef NI_DEST_CHECK_EN
      rx_misroute <= 1'b0;
`endif
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_ADDR_W'(1);
      if (rx_pop) begin
        rx_rd_ptr  <= rx_rd_ptr + RX_ADDR_W'(1);
        rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_ADDR_W + 1)'(1);
        2'b01:   rx_count <= rx_count - (RX_ADDR_W + 1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (bus.i_routerValid && dest_ok && rx_full && !rx_pop) begin
        rx_overflow <= 1'b1;
      end
`ifdef NI_DEST_CHECK_EN
      if (bus.i_routerValid && !dest_ok) begin
        rx_misroute <= 1'b1;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_network_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_network_interface
//  Description : Directed self-checking bench for network_interface
//                (4x4 mesh, node (1,1), 4-deep RX FIFO, 12-bit packets).
//                Exercises NI_DEST_CHECK_EN checks when the macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_network_interface;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  network_interface_if #(.GRID_WIDTH(4), .CNT_W(16)) bus ();

  network_interface #(
    .GRID_WIDTH (4),
    .NI_ROW     (1),
    .NI_COL     (1),
    .RX_ADDR_W  (2),
    .CNT_W      (16)
  ) dut (
    .i_clk  (clk),
    .i_srst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic [1:0] r, input logic [1:0] c);
    bus.i_routerPacket = {d, r, c};
    bus.i_routerValid  = 1'b1;
    tick();
    bus.i_routerValid  = 1'b0;
    bus.i_routerPacket = '0;
    #1;
  endtask

  task automatic tx_req(input logic [7:0] d, input logic [1:0] r, input logic [1:0] c);
    bus.i_txData    = d;
    bus.i_txDestRow = r;
    bus.i_txDestCol = c;
    bus.i_txValid   = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus.i_txData       = '0;
    bus.i_txDestRow    = '0;
    bus.i_txDestCol    = '0;
    bus.i_txValid      = 1'b0;
    bus.i_routerReady  = 1'b0;
    bus.i_routerPacket = '0;
    bus.i_routerValid  = 1'b0;
    bus.i_rxReady      = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_txReady",     bus.o_txReady, 1);
    check("rst_routerReady", bus.o_routerReady, 1);
    check("rst_routerValid", bus.o_routerValid, 0);
    check("rst_routerPacket", bus.o_routerPacket, 0);
    check("rst_rxValid",     bus.o_rxValid, 0);
    check("rst_rxData",      bus.o_rxData, 0);
    check("rst_overflow",    bus.o_rxOverflow, 0);
    check("rst_txCount",     bus.o_txCount, 0);
    check("rst_rxCount",     bus.o_rxCount, 0);

    // Single TX with the router ready
    bus.i_routerReady = 1'b1;
    #1;
    check("tx1_valid_before", bus.o_routerValid, 0);
    tx_req(8'hA5, 2'd2, 2'd1);
    bus.i_txValid = 1'b0;
    #1;
    check("tx1_valid",  bus.o_routerValid, 1);
    check("tx1_packet", bus.o_routerPacket, 12'hA59);
    tick();
    check("tx1_count",  bus.o_txCount, 1);
    check("tx1_idle",   bus.o_routerValid, 0);

    // TX backpressure: three requests, only two fit
    bus.i_routerReady = 1'b0;
    tx_req(8'h11, 2'd1, 2'd0);
    check("bp_ready_1", bus.o_txReady, 1);
    tx_req(8'h22, 2'd3, 2'd3);
    check("bp_ready_full", bus.o_txReady, 0);
    tx_req(8'h33, 2'd0, 2'd0);
    check("bp_valid_held", bus.o_routerValid, 0);
    check("bp_packet_zero", bus.o_routerPacket, 0);
    check("bp_ready_still", bus.o_txReady, 0);
    bus.i_txValid     = 1'b0;
    bus.i_routerReady = 1'b1;
    #1;
    check("bp_first_valid", bus.o_routerValid, 1);
    check("bp_first_pkt",   bus.o_routerPacket, 12'h114);
    tick();
    check("bp_second_valid", bus.o_routerValid, 1);
    check("bp_second_pkt",   bus.o_routerPacket, 12'h22F);
    tick();
    check("bp_done_valid", bus.o_routerValid, 0);
    check("bp_txCount",    bus.o_txCount, 3);
    check("bp_txReady",    bus.o_txReady, 1);

    // RX fill with the core stalled
    rx_send(8'hA1, 2'd1, 2'd1);
    check("rx1_routerReady", bus.o_routerReady, 1);
    check("rx1_valid",       bus.o_rxValid, 1);
    check("rx1_data",        bus.o_rxData, 8'hA1);
    rx_send(8'hA2, 2'd1, 2'd1);
    check("rx2_routerReady", bus.o_routerReady, 1);
    rx_send(8'hA3, 2'd1, 2'd1);
    check("rx3_routerReady", bus.o_routerReady, 0);
    rx_send(8'hA4, 2'd1, 2'd1);
    check("rx4_overflow",    bus.o_rxOverflow, 0);
    rx_send(8'hA5, 2'd1, 2'd1);
    check("rx5_overflow",    bus.o_rxOverflow, 1);
    check("rx5_head",        bus.o_rxData, 8'hA1);

    // RX drain in arrival order
    bus.i_rxReady = 1'b1;
    #1;
    check("drain_0", bus.o_rxData, 8'hA1);
    tick();
    check("drain_1", bus.o_rxData, 8'hA2);
    tick();
    check("drain_2", bus.o_rxData, 8'hA3);
    tick();
    check("drain_3", bus.o_rxData, 8'hA4);
    tick();
    check("drain_empty",   bus.o_rxValid, 0);
    check("drain_rxCount", bus.o_rxCount, 4);
    check("drain_ready",   bus.o_routerReady, 1);
    check("drain_ovf_sticky", bus.o_rxOverflow, 1);
    bus.i_rxReady = 1'b0;

    // Mid-operation reset with TX holding 2 and RX holding 3
    bus.i_routerReady = 1'b0;
    tx_req(8'h44, 2'd0, 2'd1);
    tx_req(8'h55, 2'd1, 2'd2);
    bus.i_txValid = 1'b0;
    rx_send(8'hB1, 2'd1, 2'd1);
    rx_send(8'hB2, 2'd1, 2'd1);
    rx_send(8'hB3, 2'd1, 2'd1);
    check("mid_txReady_pre", bus.o_txReady, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_routerReady = 1'b1;
    #1;
    check("mid_routerValid", bus.o_routerValid, 0);
    check("mid_rxValid",     bus.o_rxValid, 0);
    check("mid_txCount",     bus.o_txCount, 0);
    check("mid_rxCount",     bus.o_rxCount, 0);
    check("mid_overflow",    bus.o_rxOverflow, 0);
    check("mid_txReady",     bus.o_txReady, 1);
    check("mid_routerReady", bus.o_routerReady, 1);

    // Simultaneous push and pop while full
    rx_send(8'hC1, 2'd1, 2'd1);
    rx_send(8'hC2, 2'd1, 2'd1);
    rx_send(8'hC3, 2'd1, 2'd1);
    rx_send(8'hC4, 2'd1, 2'd1);
    check("full_routerReady", bus.o_routerReady, 0);
    bus.i_routerPacket = {8'hC5, 2'd1, 2'd1};
    bus.i_routerValid  = 1'b1;
    bus.i_rxReady      = 1'b1;
    tick();
    bus.i_routerValid  = 1'b0;
    bus.i_rxReady      = 1'b0;
    #1;
    check("pp_overflow", bus.o_rxOverflow, 0);
    check("pp_head",     bus.o_rxData, 8'hC2);
    check("pp_ready",    bus.o_routerReady, 0);
    bus.i_rxReady = 1'b1;
    #1;
    check("pp_drain_0", bus.o_rxData, 8'hC2);
    tick();
    check("pp_drain_1", bus.o_rxData, 8'hC3);
    tick();
    check("pp_drain_2", bus.o_rxData, 8'hC4);
    tick();
    check("pp_drain_3", bus.o_rxData, 8'hC5);
    tick();
    check("pp_empty",   bus.o_rxValid, 0);
    check("pp_rxCount", bus.o_rxCount, 5);
    bus.i_rxReady = 1'b0;

`ifdef NI_DEST_CHECK_EN
    // Destination filtering for node (1,1)
    check("mis_initial", bus.o_rxMisroute, 0);
    rx_send(8'hD1, 2'd2, 2'd3);
    check("mis_dropped",  bus.o_rxValid, 0);
    check("mis_flag",     bus.o_rxMisroute, 1);
    check("mis_no_ovf",   bus.o_rxOverflow, 0);
    rx_send(8'hD2, 2'd1, 2'd1);
    check("mis_ok_valid", bus.o_rxValid, 1);
    check("mis_ok_data",  bus.o_rxData, 8'hD2);
    bus.i_rxReady = 1'b1;
    tick();
    bus.i_rxReady = 1'b0;
    #1;
    check("mis_ok_count", bus.o_rxCount, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
